ifetch_prefetch: RTL and testbench

Instruction fetch front-end that sits directly upstream of the single-cycle core. Owns the fetch PC and issues word requests to a variable-latency instruction memory. Buffers returned instructions, each with its PC, in a small FIFO. Hands them to the core over a valid/ready interface and flushes on taken branch/jump redirects.

---
 rtl/ifetch_prefetch.sv | 177 +++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction fetch front-end: owns the fetch PC, issues one outstanding imem request at a time,
// buffers {instruction, PC} pairs in a small FIFO and flushes on redirect. Optional counters: IFETCH_PERF_EN.
`timescale 1ns/1ps
module ifetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_starve_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic             r_active;
    logic [31:0]      r_fetchPc;
    logic [31:0]      r_reqPc;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_instMem [DEPTH];
    logic [31:0]      r_pcMem   [DEPTH];
    logic [31:0]      r_inst;
    logic [31:0]      r_instPc;

    logic             w_full;
    logic             w_req;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_redirectPc;
    logic [CNT_W-1:0] w_countAfterPop;
    logic [PTR_W-1:0] w_headIdx;
    logic [31:0]      w_nextInst;
    logic [31:0]      w_nextInstPc;

    // r_active keeps imem_req low in the first cycle out of reset.
    assign w_full       = (r_count == FULL_COUNT);
    assign w_req        = r_active && (r_state == S_ISSUE) && !w_full;
    assign w_accept     = w_req && imem_gnt;
    assign w_push       = !redirect && (r_state == S_WAIT) && imem_rvalid;
    assign w_pop        = !redirect && (r_count != '0) && inst_ready;
    assign w_redirectPc = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req   = w_req;
    assign imem_addr  = r_fetchPc;
    assign inst_valid = (r_count != '0);
    assign inst       = r_inst;
    assign inst_pc    = r_instPc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_ISSUE;
            r_active  <= 1'b0;
            r_fetchPc <= RESET_PC;
            r_reqPc   <= RESET_PC;
        end else begin
            r_active <= 1'b1;
            if (redirect) begin
                r_fetchPc <= w_redirectPc;
                // A request granted in or before this cycle belongs to the old path and must be drained.
                case (r_state)
                    S_ISSUE: r_state <= w_accept ? S_DRAIN : S_ISSUE;
                    default: r_state <= imem_rvalid ? S_ISSUE : S_DRAIN;
                endcase
            end else begin
                case (r_state)
                    S_ISSUE: begin
                        if (w_accept) begin
                            r_state   <= S_WAIT;
                            r_reqPc   <= r_fetchPc;
                            r_fetchPc <= r_fetchPc + 32'd4;
                        end
                    end
                    S_WAIT:  if (imem_rvalid) r_state <= S_ISSUE;
                    S_DRAIN: if (imem_rvalid) r_state <= S_ISSUE;
                    default: r_state <= S_ISSUE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_push);
            r_rptr  <= r_rptr + PTR_W'(w_pop);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_instMem[r_wptr] <= imem_rdata;
            r_pcMem[r_wptr]   <= r_reqPc;
        end
    end

    // Head registers: next head is an existing entry if one survives the pop, else the pushed word.
    assign w_countAfterPop = r_count - CNT_W'(w_pop);
    assign w_headIdx       = r_rptr + PTR_W'(w_pop);

    always_comb begin
        w_nextInst   = r_inst;
        w_nextInstPc = r_instPc;
        if (w_countAfterPop != '0) begin
            w_nextInst   = r_instMem[w_headIdx];
            w_nextInstPc = r_pcMem[w_headIdx];
        end else if (w_push) begin
            w_nextInst   = imem_rdata;
            w_nextInstPc = r_reqPc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inst   <= '0;
            r_instPc <= '0;
        end else if (!redirect) begin
            r_inst   <= w_nextInst;
            r_instPc <= w_nextInstPc;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perfFetch;
    logic [31:0] r_perfFlush;
    logic [31:0] r_perfStarve;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perfFetch  <= '0;
            r_perfFlush  <= '0;
            r_perfStarve <= '0;
        end else begin
            if (w_push)           r_perfFetch  <= r_perfFetch + 32'd1;
            if (redirect)         r_perfFlush  <= r_perfFlush + 32'd1;
            if (r_count == '0)    r_perfStarve <= r_perfStarve + 32'd1;
        end
    end

    assign perf_fetch_cnt  = r_perfFetch;
    assign perf_flush_cnt  = r_perfFlush;
    assign perf_starve_cnt = r_perfStarve;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch: a random-latency memory model feeds the DUT and a monitor
// compares every delivered {inst_pc, inst} against the expected sequential program stream.
`timescale 1ns/1ps
module tb_ifetch_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perfFetch;
    logic [31:0] perfFlush;
    logic [31:0] perfStarve;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] expPc[$];
    logic [31:0] expInst[$];
    int segDelivered   = 0;
    int totalDelivered = 0;

    int          gntProb  = 100;
    int          latMin   = 0;
    int          latMax   = 0;
    int          spurProb = 0;
    bit          memBusy  = 1'b0;
    int          memLat   = 0;
    logic [31:0] memAddr  = '0;
    int          grantCount = 0;
    logic [31:0] lastGrantAddr = '0;

    ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perfFetch),
        .perf_flush_cnt  (perfFlush),
        .perf_starve_cnt (perfStarve)
`endif
    );

    always #5 clk = ~clk;

    // Program image: every word address holds a distinct, address-derived instruction.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // After reset or redirect the core must see target, target+4, ... in program order.
    task automatic loadExpected(input logic [31:0] target);
        logic [31:0] pc;
        expPc.delete();
        expInst.delete();
        pc = target & 32'hFFFF_FFFC;
        for (int i = 0; i < 1024; i++) begin
            expPc.push_back(pc);
            expInst.push_back(memWord(pc));
            pc = pc + 32'd4;
        end
        segDelivered = 0;
    endtask

    task automatic applyStimulus(input logic rstV, input logic readyV, input logic redirV, input logic [31:0] redirPcV);
        @(negedge clk);
        #1;
        rst         = rstV;
        inst_ready  = readyV;
        redirect    = redirV;
        redirect_pc = redirPcV;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"},   {31'b0, imem_req},   32'd0);
        checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
        checkOutput({tag, "_inst"},  inst,                32'd0);
        checkOutput({tag, "_pc"},    inst_pc,             32'd0);
        checkOutput({tag, "_addr"},  imem_addr,           RESET_PC);
    endtask

    // Memory model: one request at a time, response 1+latency cycles after grant, random
    // garbage rvalid pulses only when nothing is outstanding.
    always begin
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (memBusy) begin
            if (memLat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(memAddr);
                memBusy     = 1'b0;
            end else begin
                memLat--;
            end
        end else if (imem_req === 1'b1 && $urandom_range(99) < gntProb) begin
            imem_gnt      = 1'b1;
            memBusy       = 1'b1;
            memAddr       = imem_addr;
            memLat        = $urandom_range(latMax, latMin);
            grantCount++;
            lastGrantAddr = imem_addr;
        end else if ($urandom_range(99) < spurProb) begin
            imem_rvalid = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold-stability of both interfaces.
    logic        holdPending = 1'b0;
    logic [31:0] holdInst;
    logic [31:0] holdPc;
    logic        reqPending  = 1'b0;
    logic [31:0] reqAddr;

    always begin
        @(negedge clk);
        #2;
        if (rst === 1'b1) begin
            if (holdPending) begin
                checkOutput("hold_valid", {31'b0, inst_valid}, 32'd1);
                checkOutput("hold_inst",  inst,    holdInst);
                checkOutput("hold_pc",    inst_pc, holdPc);
            end
            if (reqPending) begin
                checkOutput("req_held",  {31'b0, imem_req}, 32'd1);
                checkOutput("addr_held", imem_addr, reqAddr);
            end
            if (imem_req) checkOutput("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (inst_valid && inst_ready && !redirect) begin
                if (expPc.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL deliver_unexpected: got pc %h, expected no delivery", inst_pc);
                end else begin
                    checkOutput("deliver_pc",   inst_pc, expPc.pop_front());
                    checkOutput("deliver_inst", inst,    expInst.pop_front());
                end
                segDelivered++;
                totalDelivered++;
            end
            holdPending = inst_valid && !inst_ready && !redirect;
            holdInst    = inst;
            holdPc      = inst_pc;
            reqPending  = imem_req && !imem_gnt && !redirect;
            reqAddr     = imem_addr;
        end else begin
            holdPending = 1'b0;
            reqPending  = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int d0;
        int g0;
        int readyProb;
        int sinceRedir;
        int r;
        logic rdy;
        logic [31:0] tgt;
        logic [31:0] expGrant;

        rst = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        loadExpected(RESET_PC);

        // Power-up reset, then streaming with immediate grant and one-cycle latency.
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkResetState("reset");
        gntProb = 100; latMin = 0; latMax = 0; spurProb = 0;
        expGrant = RESET_PC;
        d0 = 0;
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1, 1, 0, 0);
            if (i == 10) d0 = totalDelivered;
            if (i == 30) checkOutput("stream_rate", 32'(totalDelivered - d0), 32'd10);
            if (imem_gnt) begin
                checkOutput("stream_grant_addr", imem_addr, expGrant);
                expGrant = expGrant + 32'd4;
            end
        end

        // Core stalled: exactly DEPTH fetches, then requests stop until space frees.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        loadExpected(RESET_PC);
        g0 = grantCount;
        repeat (20) applyStimulus(1, 0, 0, 0);
        checkOutput("full_grants", 32'(grantCount - g0), 32'(DEPTH));
        checkOutput("full_req",    {31'b0, imem_req},   32'd0);
        checkOutput("full_valid",  {31'b0, inst_valid}, 32'd1);
        checkOutput("full_head",   inst_pc,             RESET_PC);
        repeat (30) applyStimulus(1, 1, 0, 0);
        checkOutput("full_drain", {31'b0, segDelivered >= 8}, 32'd1);

        // Redirect to a misaligned target while a request is outstanding; stale word must be dropped.
        latMin = 3; latMax = 3;
        n = 0;
        do begin applyStimulus(1, 1, 0, 0); n++; end while (!imem_gnt && n < 50);
        checkOutput("wait_gnt_a", {31'b0, imem_gnt}, 32'd1);
        applyStimulus(1, 1, 1, 32'h0000_0103);
        loadExpected(32'h0000_0103);
        g0 = grantCount;
        n = 0;
        do begin applyStimulus(1, 1, 0, 0); n++; end while (grantCount == g0 && n < 30);
        checkOutput("redir_wait_addr", lastGrantAddr, 32'h0000_0100);
        repeat (20) applyStimulus(1, 1, 0, 0);
        checkOutput("redir_wait_progress", {31'b0, segDelivered > 0}, 32'd1);

        // Redirect in the very cycle the memory grants.
        latMin = 2; latMax = 2;
        n = 0;
        do begin applyStimulus(1, 1, 0, 0); n++; end while (!imem_gnt && n < 50);
        checkOutput("wait_gnt_b", {31'b0, imem_gnt}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2002;
        loadExpected(32'h0000_2002);
        g0 = grantCount;
        n = 0;
        do begin applyStimulus(1, 1, 0, 0); n++; end while (grantCount == g0 && n < 30);
        checkOutput("redir_gnt_addr", lastGrantAddr, 32'h0000_2000);
        repeat (20) applyStimulus(1, 1, 0, 0);
        checkOutput("redir_gnt_progress", {31'b0, segDelivered > 0}, 32'd1);

        // Reset while waiting, response lands during reset, then memory withholds grants.
        latMin = 3; latMax = 3;
        n = 0;
        do begin applyStimulus(1, 1, 0, 0); n++; end while (!imem_gnt && n < 50);
        checkOutput("wait_gnt_c", {31'b0, imem_gnt}, 32'd1);
        applyStimulus(1, 1, 0, 0);
        repeat (4) applyStimulus(0, 1, 0, 0);
        checkResetState("midreset");
        loadExpected(RESET_PC);
        gntProb = 0;
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, 0);
            checkOutput("nognt_req",   {31'b0, imem_req},   32'd1);
            checkOutput("nognt_addr",  imem_addr,           RESET_PC);
            checkOutput("nognt_valid", {31'b0, inst_valid}, 32'd0);
        end
        gntProb = 100; latMin = 0; latMax = 0;
        repeat (20) applyStimulus(1, 1, 0, 0);
        checkOutput("nognt_progress", {31'b0, segDelivered > 0}, 32'd1);

        // Randomised traffic: grant/latency/ready mixes, spurious rvalid, redirects (incl. wrap), resets.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        loadExpected(RESET_PC);
        d0 = totalDelivered;
        sinceRedir = 0;
        readyProb = 100;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 40 == 0) begin
                gntProb   = $urandom_range(100, 20);
                latMin    = 0;
                latMax    = $urandom_range(4, 0);
                spurProb  = $urandom_range(20, 0);
                readyProb = $urandom_range(100, 30);
            end
            rdy = ($urandom_range(99) < readyProb);
            r   = $urandom_range(999);
            if (r < 3) begin
                applyStimulus(0, rdy, 0, 0);
                applyStimulus(0, rdy, 0, 0);
                loadExpected(RESET_PC);
                sinceRedir = 0;
            end else if (r < 40 || sinceRedir > 150) begin
                if ($urandom_range(1) == 1) tgt = 32'($urandom_range(4095));
                else                        tgt = 32'hFFFF_FFE0 + 32'($urandom_range(31));
                applyStimulus(1, rdy, 1, tgt);
                loadExpected(tgt);
                sinceRedir = 0;
            end else begin
                applyStimulus(1, rdy, 0, $urandom);
                sinceRedir++;
            end
        end
        checkOutput("random_progress", {31'b0, (totalDelivered - d0) > 100}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
